// File: rtl/ps2_host_tx_if.sv
// Command handshake and status bundle between the CPU side and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       rx_inhibit;
  logic       tx_done;
  logic       tx_ack_ok;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, rx_inhibit, tx_done, tx_ack_ok, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, rx_inhibit, tx_done, tx_ack_ok, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, LSB-first odd-parity frame
// clocked by the device, ACK check, with open-drain pads driven through output enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  ps2_host_tx_if.slave host,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ABORT
  } state_t;

  // Pad synchronizers; index 0 = clock, 1 = data. Idle bus level is high.
  logic [1:0] pad_raw;
  logic [1:0] pad_sync;
  assign pad_raw = {ps2_data_in, ps2_clk_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pad_raw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign pad_sync[gi] = sync_reg;
    end
  endgenerate

  logic clk_sync;
  logic data_sync;
  assign clk_sync  = pad_sync[0];
  assign data_sync = pad_sync[1];

  logic          clk_filt_reg;
  logic          clk_filt_d_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_filt_reg   <= 1'b1;
      clk_filt_d_reg <= 1'b1;
      filt_cnt_reg   <= '0;
    end else begin
      clk_filt_d_reg <= clk_filt_reg;
      if (clk_sync != clk_filt_reg) begin
        if (filt_cnt_reg == FILTER_LAST) begin
          clk_filt_reg <= clk_sync;
          filt_cnt_reg <= '0;
        end else begin
          filt_cnt_reg <= filt_cnt_reg + 1'b1;
        end
      end else begin
        filt_cnt_reg <= '0;
      end
    end
  end

  assign fall = clk_filt_d_reg & ~clk_filt_reg;

  state_t        state_reg, state_next;
  logic [9:0]    shift_reg, shift_next;
  logic [3:0]    bit_cnt_reg, bit_cnt_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [IW-1:0] inh_cnt_reg, inh_cnt_next;
  logic          clk_oe_reg, clk_oe_next;
  logic          data_oe_reg, data_oe_next;
  logic          ack_ok_reg, ack_ok_next;
  logic          ready_reg, ready_next;
  logic          done_reg, done_next;
  logic          ack_out_reg, ack_out_next;
  logic          err_reg, err_next;
  logic          timed;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      timer_reg   <= '0;
      inh_cnt_reg <= '0;
      clk_oe_reg  <= 1'b0;
      data_oe_reg <= 1'b0;
      ack_ok_reg  <= 1'b0;
      ready_reg   <= 1'b0;
      done_reg    <= 1'b0;
      ack_out_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      timer_reg   <= timer_next;
      inh_cnt_reg <= inh_cnt_next;
      clk_oe_reg  <= clk_oe_next;
      data_oe_reg <= data_oe_next;
      ack_ok_reg  <= ack_ok_next;
      ready_reg   <= ready_next;
      done_reg    <= done_next;
      ack_out_reg <= ack_out_next;
      err_reg     <= err_next;
    end
  end

  assign timed = (state_reg == ST_SEND) || (state_reg == ST_ACK) || (state_reg == ST_WAIT_IDLE);

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    timer_next   = timer_reg;
    inh_cnt_next = inh_cnt_reg;
    clk_oe_next  = clk_oe_reg;
    data_oe_next = data_oe_reg;
    ack_ok_next  = ack_ok_reg;
    done_next    = 1'b0;
    ack_out_next = 1'b0;
    err_next     = 1'b0;

    if (timed) begin
      timer_next = fall ? '0 : timer_reg + 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        clk_oe_next  = 1'b0;
        data_oe_next = 1'b0;
        if (host.tx_valid && ready_reg) begin
          shift_next   = {1'b1, ~^host.tx_data, host.tx_data};
          bit_cnt_next = '0;
          timer_next   = '0;
          inh_cnt_next = '0;
          ack_ok_next  = 1'b0;
          clk_oe_next  = 1'b1;
          state_next   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt_reg == INHIBIT_LAST) begin
          data_oe_next = 1'b1;
          state_next   = ST_REQUEST;
        end else begin
          inh_cnt_next = inh_cnt_reg + 1'b1;
        end
      end
      ST_REQUEST: begin
        clk_oe_next = 1'b0;
        timer_next  = '0;
        state_next  = ST_SEND;
      end
      ST_SEND: begin
        // Each device falling edge presents the next frame bit; the tenth is the stop bit.
        if (fall) begin
          data_oe_next = ~shift_reg[0];
          shift_next   = {1'b0, shift_reg[9:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 4'd9) begin
            state_next = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (fall) begin
          ack_ok_next = ~data_sync;
          state_next  = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_filt_reg && data_sync) begin
          done_next    = 1'b1;
          ack_out_next = ack_ok_reg;
          err_next     = ~ack_ok_reg;
          state_next   = ST_IDLE;
        end
      end
      ST_ABORT: begin
        done_next  = 1'b1;
        err_next   = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A fall in the expiry cycle wins; completion in WAIT_IDLE also wins.
    if (timed && !fall && (timer_reg == TIMEOUT_LAST) && (state_next == state_reg)) begin
      clk_oe_next  = 1'b0;
      data_oe_next = 1'b0;
      state_next   = ST_ABORT;
    end
  end

  assign ready_next = (state_next == ST_IDLE);

  assign host.tx_ready   = ready_reg;
  assign host.busy       = (state_reg != ST_IDLE);
  assign host.rx_inhibit = (state_reg != ST_IDLE);
  assign host.tx_done    = done_reg;
  assign host.tx_ack_ok  = ack_out_reg;
  assign host.tx_error   = err_reg;
  assign ps2_clk_oe      = clk_oe_reg;
  assign ps2_data_oe     = data_oe_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a behavioural PS/2 device and frame reference model.
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int FLT  = 2;
  localparam int TMO  = 200;
  localparam int HALF = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic ps2_clk_oe, ps2_data_oe;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic glitch       = 1'b0;
  logic ps2_clk_in, ps2_data_in;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low | glitch);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx_if host ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .host       (host),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int accept_cnt = 0;
  int done_cnt = 0;
  int err_orphan = 0;
  int t_done = 0;
  logic last_ack, last_err;
  logic [1:0] last_oe;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock step; also tallies accepts, done pulses and stray error pulses.
  task automatic tick();
    logic v, r, rs;
    v  = host.tx_valid;
    r  = host.tx_ready;
    rs = reset;
    @(negedge clock);
    cyc++;
    if (v && r && !rs) accept_cnt++;
    if (host.tx_done) begin
      done_cnt++;
      last_ack = host.tx_ack_ok;
      last_err = host.tx_error;
      last_oe  = {ps2_clk_oe, ps2_data_oe};
      t_done   = cyc;
    end
    if (host.tx_error && !host.tx_done) err_orphan++;
  endtask

  function automatic logic [9:0] frame_model(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d};
  endfunction

  // mode: 0 normal, 1 device stops after fall 4, 2 reset after fall 5, 3 clock glitch
  task automatic run_frame(input logic [7:0] d, input int mode, input bit ack, input bit hold_valid);
    int n, cnt, acc0, done0, t_fall4;
    logic [9:0] got_bits;
    logic req_seen;
    acc0 = accept_cnt;
    done0 = done_cnt;
    got_bits = '0;
    req_seen = 1'b0;
    t_fall4 = 0;
    $display("[TB] frame %02h mode %0d ack %0b", d, mode, ack);

    n = 0;
    while (!host.tx_ready && n < 50) begin tick(); n++; end
    check_eq("ready_before", host.tx_ready, 1);
    host.tx_data = d;
    host.tx_valid = 1'b1;
    tick();
    if (!hold_valid) host.tx_valid = 1'b0;
    check_eq("ready_drop", host.tx_ready, 0);
    check_eq("busy", host.busy, 1);
    check_eq("rx_inhibit", host.rx_inhibit, 1);
    check_eq("inhibit_data_oe", ps2_data_oe, 0);

    cnt = 0;
    n = 0;
    while (ps2_clk_oe && n < 100) begin
      cnt++;
      if (ps2_data_oe) req_seen = 1'b1;
      tick();
      n++;
    end
    check_eq("clk_oe_len", cnt, INH + 1);
    check_eq("request_seen", req_seen, 1);
    repeat (29) tick();
    check_eq("start_bit", ps2_data_oe, 1);

    for (int k = 1; k <= 11; k++) begin
      if (mode == 1 && k == 5) begin
        repeat (150) tick();
        check_eq("to_busy_held", host.busy, 1);
        n = 0;
        while (done_cnt == done0 && n < 150) begin tick(); n++; end
        check_eq("to_done", done_cnt - done0, 1);
        check_eq("to_err", last_err, 1);
        check_eq("to_ack", last_ack, 0);
        check_eq("to_oe", last_oe, 0);
        check_eq("to_window", (t_done - t_fall4 >= 200) && (t_done - t_fall4 <= 215), 1);
        tick();
        check_eq("to_ready", host.tx_ready, 1);
        return;
      end
      if (k == 4) t_fall4 = cyc;
      dev_clk_low = 1'b1;
      repeat (HALF) tick();
      if (k <= 10) got_bits[k-1] = ~ps2_data_oe;
      dev_clk_low = 1'b0;
      if (mode == 2 && k == 5) begin
        repeat (3) tick();
        reset = 1'b1;
        host.tx_valid = 1'b0;
        tick();
        check_eq("rst_clk_oe", ps2_clk_oe, 0);
        check_eq("rst_data_oe", ps2_data_oe, 0);
        check_eq("rst_busy", host.busy, 0);
        check_eq("rst_no_done", done_cnt - done0, 0);
        reset = 1'b0;
        repeat (2) tick();
        check_eq("rst_ready", host.tx_ready, 1);
        check_eq("rst_accept_once", accept_cnt - acc0, 1);
        check_eq("rst_no_done_after", done_cnt - done0, 0);
        return;
      end
      for (int j = 0; j < HALF; j++) begin
        if (k == 10 && j == HALF - 5 && ack) dev_data_low = 1'b1;
        if (k == 11 && j == 5) dev_data_low = 1'b0;
        glitch = (mode == 3 && k == 3 && j == 10);
        tick();
      end
      glitch = 1'b0;
    end
    dev_data_low = 1'b0;

    check_eq("frame_bits", got_bits, frame_model(d));
    check_eq("parity_bit", got_bits[8], frame_model(d) >> 8 & 10'd1);
    n = 0;
    while (done_cnt == done0 && n < 100) begin tick(); n++; end
    host.tx_valid = 1'b0;
    check_eq("done_once", done_cnt - done0, 1);
    check_eq("ack_ok", last_ack, ack);
    check_eq("error", last_err, !ack);
    check_eq("accept_once", accept_cnt - acc0, 1);
    check_eq("ready_after", host.tx_ready, 1);
  endtask

  initial begin
    logic [7:0] rd;
    bit ra;
    host.tx_data = 8'h00;
    host.tx_valid = 1'b0;
    last_ack = 1'b0;
    last_err = 1'b0;
    last_oe = 2'b00;
    repeat (5) tick();
    check_eq("reset_ready", host.tx_ready, 0);
    check_eq("reset_busy", host.busy, 0);
    check_eq("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check_eq("reset_done", host.tx_done, 0);
    reset = 1'b0;
    tick();
    check_eq("ready_after_reset", host.tx_ready, 1);

    run_frame(8'hF4, 0, 1'b1, 1'b0);
    run_frame(8'hED, 0, 1'b1, 1'b0);
    rd = 8'($urandom_range(0, 255));
    run_frame(rd, 0, 1'b0, 1'b0);
    rd = 8'($urandom_range(0, 255));
    run_frame(rd, 1, 1'b1, 1'b0);
    run_frame(8'hFF, 0, 1'b1, 1'b0);
    rd = 8'($urandom_range(0, 255));
    run_frame(rd, 2, 1'b1, 1'b1);
    rd = 8'($urandom_range(0, 255));
    run_frame(rd, 3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      run_frame(rd, 0, ra, 1'b0);
    end
    check_eq("error_without_done", err_orphan, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
